// File: rtl/mem_arbiter0.sv
// Two-master round-robin arbiter sharing the memory0 port.
// Each access runs grant -> ACCESS (held WAIT_CYCLES extra) -> one-cycle ACK.
module mem_arbiter0 #(
    parameter logic [31:0] MEMSIZE     = 32'h7000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] abus,
    output logic [31:0] dbus_out,
    input  logic [31:0] dbus_in,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

    localparam logic [31:0] ADDR_MAX  = MEMSIZE - 32'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic        m_en_q, m_en_d;
    logic        m_rw_q, m_rw_d;
    logic [1:0]  m_size_q, m_size_d;
    logic [31:0] abus_q, abus_d;
    logic [31:0] dbus_out_q, dbus_out_d;
    logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;

    // Winner selection: a lone requester wins; on a tie the master not served last wins.
    logic        win;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    always_comb begin
        win = m1_req;
        if (m0_req && m1_req) begin
            win = ~last_q;
        end
        sel_rw    = win ? m1_rw    : m0_rw;
        sel_size  = win ? m1_size  : m0_size;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_d    = state_q;
        m_en_d     = m_en_q;
        m_rw_d     = m_rw_q;
        m_size_d   = m_size_q;
        abus_d     = abus_q;
        dbus_out_d = dbus_out_q;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        last_d     = last_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    m_rw_d     = sel_rw;
                    m_size_d   = sel_size;
                    abus_d     = sel_addr;
                    dbus_out_d = sel_wdata;
                    owner_d    = win;
                    last_d     = win;
                    cnt_d      = WAIT_INIT;
                    busy_d     = 1'b1;
                    // Out-of-range requests skip memory entirely and acknowledge with an error.
                    if (sel_addr > ADDR_MAX) begin
                        state_d  = ACK;
                        m_en_d   = 1'b0;
                        m0_ack_d = ~win;
                        m0_err_d = ~win;
                        m1_ack_d = win;
                        m1_err_d = win;
                    end else begin
                        state_d = ACCESS;
                        m_en_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (m_rw_q) begin
                        if (owner_q) begin
                            m1_rdata_d = dbus_in;
                        end else begin
                            m0_rdata_d = dbus_in;
                        end
                    end
                    state_d  = ACK;
                    m_en_d   = 1'b0;
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                m_en_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            m_en_q     <= 1'b0;
            m_rw_q     <= 1'b1;
            m_size_q   <= 2'b00;
            abus_q     <= 32'd0;
            dbus_out_q <= 32'd0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            m_en_q     <= m_en_d;
            m_rw_q     <= m_rw_d;
            m_size_q   <= m_size_d;
            abus_q     <= abus_d;
            dbus_out_q <= dbus_out_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_en     = m_en_q;
    assign m_rw     = m_rw_q;
    assign m_size   = m_size_q;
    assign abus     = abus_q;
    assign dbus_out = dbus_out_q;
    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: doc/mem_arbiter0.md
Name: mem_arbiter0

Overview:
- Two-master arbiter that shares the single memory0 port (en/rw/m_size/abus/dbus_in/dbus_out) between master 0 (cpu0 load/store/fetch path) and master 1 (DMA/IO engine).
- Sequences each access as a fixed multi-cycle transaction: arbitrate, drive memory, capture read data, acknowledge.
- Round-robin fairness on simultaneous requests. Out-of-range addresses are rejected with an error acknowledge and never reach memory.

Parameters:
- MEMSIZE, 'h7000, memory size in bytes; addresses above MEMSIZE-4 are out of range.
- WAIT_CYCLES, 0, extra cycles the ACCESS phase is held before data capture (0..15).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request, level; held until m0_ack.
- m0_rw  input  1  1=read, 0=write.
- m0_size  input  2  operand width: 11=INT32, 10=INT24, 01=INT16, 00=BYTE.
- m0_addr  input  32  byte address.
- m0_wdata  input  32  write data.
- m0_ack  output  1  one-cycle completion pulse.
- m0_err  output  1  valid with m0_ack; 1=address out of range.
- m0_rdata  output  32  read data; registered; valid from m0_ack onward.
- m1_req, m1_rw, m1_size, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as master 0, for master 1.
- m_en  output  1  memory enable.
- m_rw  output  1  memory access mode: 1=read, 0=write.
- m_size  output  2  memory operand width.
- abus  output  32  memory address.
- dbus_out  output  32  write data to memory dbus_in.
- dbus_in  input  32  read data from memory dbus_out.
- owner  output  1  master currently granted; valid while busy.
- busy  output  1  1 in ACCESS or ACK.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, m_en=0, m_rw=1, m_size=00, abus=0, dbus_out=0, m0/m1_ack=0, m0/m1_err=0, m0/m1_rdata=0, owner=0, busy=0, last=1 (so master 0 wins the first tie), cnt=0.
- Reset mid-transaction: the transaction is abandoned with no ack, and m_en drops on the next edge.
- All outputs are registered.
- States and transitions:
  - IDLE: if no req, stay.
  - IDLE, exactly one req: grant that master.
  - IDLE, both req: grant the master != last.
  - On grant: latch rw/size/addr/wdata into abus/m_rw/m_size/dbus_out; owner=winner; last=winner; cnt=WAIT_CYCLES.
  - On grant, in range: go to ACCESS with m_en=1.
  - On grant, out of range (addr > MEMSIZE-4, unsigned): go directly to ACK with err=1 and m_en=0; memory is untouched and rdata is unchanged.
- ACCESS:
  - m_en=1 and all memory signals held stable.
  - If cnt!=0: cnt-=1 and stay.
  - If cnt==0: for a read, capture dbus_in into the owner's rdata; go to ACK with m_en=0.
- ACK:
  - Owner's ack=1 for exactly one cycle; err as decided at grant.
  - The non-owner's ack and err stay 0.
  - Next state is IDLE; ack and err return to 0.
- Latency, req seen in IDLE at cycle 0:
  - ACCESS occupies cycles 1..1+WAIT_CYCLES.
  - ack is high in cycle 2+WAIT_CYCLES.
  - IDLE resumes at cycle 3+WAIT_CYCLES.
- Requester handshake:
  - The requester must hold req and all request fields constant until it samples ack.
  - It drops req in the cycle after ack.
  - A req still high in IDLE is a new request, which allows back-to-back accesses.
- Fairness: a master with continuous requests is granted at most every other transaction when the other master also requests.
- Requests are ignored outside IDLE; they are re-evaluated only on return to IDLE.
- Memory data is byte-lane right-aligned, as memory0 provides; no sign extension in this block.
- Write transactions do not modify rdata.

Test Plan:
- Single read, WAIT_CYCLES=0: m0_req rw=1 addr=0 size=11, memory word 0=0x01020304 -> m_en high cycle 1 only, m0_ack cycle 2, m0_rdata=0x01020304, m0_err=0.
- Simultaneous requests from reset: m0 write addr=8 data=0xDEADBEEF, m1 read addr=8 -> m0 is granted first (owner=0); m1 is granted next and returns m1_rdata=0xDEADBEEF; owner alternates.
- Continuous contention for 8 transactions -> grants alternate 0,1,0,1…; each ack exactly 3 cycles apart per transaction.
- Out of range: m1 read addr=0x6FFD -> no m_en pulse, m1_ack and m1_err=1 in cycle 1, m1_rdata unchanged.
- WAIT_CYCLES=3: m0 read -> m_en high cycles 1..4, memory signals stable throughout, m0_ack in cycle 5.
- Reset asserted during ACCESS -> next edge m_en=0, no ack ever issued, state IDLE, master 0 wins the next tie.
